// File: rtl/cfr_pkg.sv
// cfr_pkg: shared types and constants for the CFR peak detector.
// Holds the detector FSM state enum and the sample pipeline depth.
package cfr_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    HOLD   = 1'b1
  } pk_state_e;

  localparam int PIPE_DEPTH = 3;

endpackage

// File: rtl/cdc_array_single.sv
// cdc_array_single: 2-FF synchronizer for a quasi-static bus.
// Ports: clk, rst_n, d_i (async input), q_o (synchronized).
module cdc_array_single #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cfr_power_calc.sv
// cfr_power_calc: two-stage I^2+Q^2 pipeline, advancing on en_i.
// Ports: clk, rst_n, en_i, i_i/q_i (signed samples), pwr_o (unsigned power).
module cfr_power_calc #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic [DATA_WIDTH-1:0]   i_i,
  input  logic [DATA_WIDTH-1:0]   q_i,
  output logic [2*DATA_WIDTH-1:0] pwr_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0] i_ext;
  logic [PW-1:0] q_ext;
  logic [PW-1:0] ii_d;
  logic [PW-1:0] qq_d;
  logic [PW-1:0] ii_q;
  logic [PW-1:0] qq_q;
  logic [PW-1:0] pwr_q;

  assign i_ext = {{DATA_WIDTH{i_i[DATA_WIDTH-1]}}, i_i};
  assign q_ext = {{DATA_WIDTH{q_i[DATA_WIDTH-1]}}, q_i};

  // Low PW bits of the sign-extended product are the exact square.
  assign ii_d = i_ext * i_ext;
  assign qq_d = q_ext * q_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ii_q  <= '0;
      qq_q  <= '0;
      pwr_q <= '0;
    end else if (en_i) begin
      ii_q  <= ii_d;
      qq_q  <= qq_d;
      pwr_q <= ii_q + qq_q;
    end
  end

  assign pwr_o = pwr_q;

endmodule

// File: rtl/cfr_peak_detect.sv
// cfr_peak_detect: flags local power maxima above a threshold with holdoff.
// Ports: I/Q in/out with valid, peak_flag, peak_power, peak_count, ctrl_*.
module cfr_peak_detect
  import cfr_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int HOLDOFF    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   data_i_in,
  input  logic [DATA_WIDTH-1:0]   data_q_in,
  input  logic                    data_valid_in,
  output logic [DATA_WIDTH-1:0]   data_i_out,
  output logic [DATA_WIDTH-1:0]   data_q_out,
  output logic                    data_valid_out,
  output logic                    peak_flag,
  output logic [2*DATA_WIDTH-1:0] peak_power,
  output logic [15:0]             peak_count,
  input  logic                    ctrl_enable,
  input  logic [DATA_WIDTH:0]     ctrl_threshold,
  input  logic                    ctrl_count_clear
);

  localparam int PW   = 2 * DATA_WIDTH;
  localparam int TW   = PW + 2;
  localparam int PC_W = $clog2(PIPE_DEPTH + 1);
  localparam logic [PC_W-1:0] PRIMED  = PC_W'(PIPE_DEPTH);
  localparam logic [7:0]      HOLD_LD = 8'(HOLDOFF);

  logic                  en_s;
  logic [DATA_WIDTH:0]   thr_s;
  logic [TW-1:0]         thr_ext;
  logic [TW-1:0]         thr2_q;
  logic [PW-1:0]         pwr;
  logic [PW-1:0]         h1_q;
  logic [PW-1:0]         h2_q;
  logic [DATA_WIDTH-1:0] di_q [PIPE_DEPTH];
  logic [DATA_WIDTH-1:0] dq_q [PIPE_DEPTH];
  logic [PC_W-1:0]       prime_q;
  logic                  primed;
  logic                  adv;
  logic                  cand;
  pk_state_e             state_q;
  pk_state_e             state_d;
  logic [7:0]            hcnt_q;
  logic [7:0]            hcnt_d;
  logic                  flag_d;
  logic [15:0]           cnt_q;
  logic [15:0]           cnt_d;
  logic [DATA_WIDTH-1:0] di_out_q;
  logic [DATA_WIDTH-1:0] dq_out_q;
  logic                  vld_q;
  logic                  flag_q;
  logic [PW-1:0]         pow_q;

  cdc_array_single #(.WIDTH(1)) u_sync_en (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ctrl_enable),
    .q_o   (en_s)
  );

  cdc_array_single #(.WIDTH(DATA_WIDTH + 1)) u_sync_thr (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ctrl_threshold),
    .q_o   (thr_s)
  );

  cfr_power_calc #(.DATA_WIDTH(DATA_WIDTH)) u_pwr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (data_valid_in),
    .i_i   (data_i_in),
    .q_i   (data_q_in),
    .pwr_o (pwr)
  );

  assign thr_ext = TW'(thr_s);
  assign primed  = (prime_q == PRIMED);
  assign adv     = data_valid_in && primed;

  // h1 is the sample leaving now, h2 its predecessor, pwr its successor.
  assign cand = (TW'(h1_q) > thr2_q)
             && (h1_q >= h2_q)
             && (h1_q > pwr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        di_q[k] <= '0;
        dq_q[k] <= '0;
      end
      thr2_q   <= '0;
      h1_q     <= '0;
      h2_q     <= '0;
      prime_q  <= '0;
      di_out_q <= '0;
      dq_out_q <= '0;
      pow_q    <= '0;
    end else begin
      thr2_q <= thr_ext * thr_ext;
      if (data_valid_in) begin
        di_q[0] <= data_i_in;
        dq_q[0] <= data_q_in;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
          di_q[k] <= di_q[k-1];
          dq_q[k] <= dq_q[k-1];
        end
        h1_q     <= pwr;
        h2_q     <= h1_q;
        di_out_q <= di_q[PIPE_DEPTH-1];
        dq_out_q <= dq_q[PIPE_DEPTH-1];
        pow_q    <= h1_q;
        if (!primed) prime_q <= prime_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    flag_d  = 1'b0;
    if (!en_s) begin
      state_d = SEARCH;
      hcnt_d  = '0;
    end else if (adv) begin
      unique case (state_q)
        SEARCH: begin
          if (cand) begin
            flag_d = 1'b1;
            if (HOLD_LD != 8'd0) begin
              state_d = HOLD;
              hcnt_d  = HOLD_LD;
            end
          end
        end
        HOLD: begin
          hcnt_d = hcnt_q - 8'd1;
          if (hcnt_q == 8'd1) state_d = SEARCH;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ctrl_count_clear) begin
      cnt_d = '0;
    end else if (flag_d && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      hcnt_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      cnt_q   <= cnt_d;
      vld_q   <= adv;
      flag_q  <= flag_d;
    end
  end

  assign data_i_out     = di_out_q;
  assign data_q_out     = dq_out_q;
  assign data_valid_out = vld_q;
  assign peak_flag      = flag_q;
  assign peak_power     = pow_q;
  assign peak_count     = cnt_q;

endmodule

// File: doc/cfr_peak_detect.md
CFR_PEAK_DETECT -- requirements
Module: cfr_peak_detect

Interface
REQ-001 Parameter DATA_WIDTH, default 16, I/Q sample width in bits (signed two's complement).
REQ-002 Parameter HOLDOFF, default 4, number of valid samples after a detected peak during which further peaks are suppressed; allowed range 0..255.
REQ-003 clk  in  1  single clock; all logic is synchronous to its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 data_i_in, data_q_in  in  DATA_WIDTH each  hard-clipped I/Q from cfr_hardclipping.
REQ-006 data_valid_in  in  1  qualifies the input sample; gaps are allowed.
REQ-007 data_i_out, data_q_out  out  DATA_WIDTH each  input samples delayed by the pipeline.
REQ-008 data_valid_out  out  1  qualifies the output sample.
REQ-009 peak_flag  out  1  high with data_valid_out when the output sample is a detected peak.
REQ-010 peak_power  out  2*DATA_WIDTH  power (I^2+Q^2) of the current output sample; valid with data_valid_out.
REQ-011 peak_count  out  16  saturating count of detected peaks.
REQ-012 ctrl_enable  in  1  1 = detect, 0 = pass-through with no flags; quasi-static.
REQ-013 ctrl_threshold  in  DATA_WIDTH+1  unsigned magnitude threshold; quasi-static.
REQ-014 ctrl_count_clear  in  1  synchronous clear of peak_count, single-cycle pulse, clk domain.

Function
REQ-015 ctrl_enable and ctrl_threshold SHALL pass through 2-FF cdc_array_single synchronizers before use.
REQ-016 All pipeline stages SHALL advance only on cycles where data_valid_in=1.
REQ-017 Power SHALL be p = I*I + Q*Q, computed unsigned in 2*DATA_WIDTH bits, with no overflow possible.
REQ-018 The threshold SHALL be squared to 2*DATA_WIDTH+2 bits, registered, and compared at that width.
REQ-019 Sample n SHALL be a candidate when p[n] > thr^2, p[n] >= p[n-1] and p[n] > p[n+1]; on a plateau, the last sample is the candidate.
REQ-020 Output sample n SHALL be presented on the cycle after the clock edge that accepts input sample n+3; data_valid_out is then a one-cycle-delayed copy of data_valid_in.
REQ-021 After reset, data_valid_out SHALL stay 0 until the 4th valid input sample has been accepted (pipeline priming).
REQ-022 The FSM SHALL have two states, SEARCH and HOLD, with these transitions:
- SEARCH -> HOLD on a candidate, asserting peak_flag and loading the holdoff counter with HOLDOFF.
- HOLD decrements the counter once per valid sample and masks candidates.
- HOLD -> SEARCH when the counter reaches 0, where the sample that reaches 0 is itself still masked.
- With HOLDOFF=0, HOLD is never entered.
REQ-023 With ctrl_enable_s=0, the FSM SHALL be forced to SEARCH, peak_flag=0, and the counter is not incremented; data latency is unchanged.
REQ-024 peak_count SHALL increment by 1 on each peak_flag, saturate at 65535, and be cleared to 0 by ctrl_count_clear; clear wins over a simultaneous increment.
REQ-025 With threshold 0, every strict local maximum of nonzero power SHALL be a candidate.

Reset
REQ-026 With rst_n low, all outputs SHALL be 0, the FSM SHALL be in SEARCH, the holdoff counter SHALL be 0, and the priming count SHALL be 0; stored power history is cleared to 0.
REQ-027 Assertion of rst_n mid-stream SHALL discard all in-flight samples; after release, operation restarts with priming per REQ-021.

Structure
REQ-028 The state enum (SEARCH, HOLD) and the pipeline-depth constant (3) SHALL live in the shared package cfr_pkg.
REQ-029 The power computation (two multipliers, adder, two register stages) SHALL be the sub-module cfr_power_calc.

Verification
REQ-030 Prime, then a single spike: continuous valid, |I|,Q=0 except I=1000 at sample 10, threshold=500 -> exactly one peak_flag, on output sample 10; peak_power=1000000; peak_count=1.
REQ-031 Plateau: powers 0, 600^2, 600^2, 0 with threshold=500 -> peak_flag on the second 600^2 sample only.
REQ-032 Holdoff: HOLDOFF=4, peaks at samples 10 and 13, then 16 -> flags at 10 and 16 only; peak_count=2.
REQ-033 Valid gaps: same stimulus as REQ-030 with data_valid_in toggling 1,0,1,0 -> identical output sample sequence and a flag on sample 10.
REQ-034 Disable/count: ctrl_enable=0 with spikes -> no flags, outputs equal to the delayed input; 65540 peaks with enable=1 -> peak_count=65535; clear on the same cycle as a flag -> 0.
REQ-035 Reset mid-stream: rst_n low for 3 cycles at sample 50 -> outputs 0 immediately; data_valid_out returns on the 4th valid sample after release.
